mc_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM: sequences the extender (EXTop/Shiftop), ALU, PC, IR, GRF and DM

---
 rtl/mc_ctrl_pkg.sv | 47 ++++
 rtl/mc_ctrl_if.sv | 38 +++
 rtl/mc_ctrl_decode.sv | 31 +++
 rtl/mc_ctrl.sv | 115 +++++++++++
 tb/tb_mc_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state codes, instruction classes and control-field encodings for the multi-cycle MIPS controller
package mc_ctrl_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;
    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR, I_NOP, I_ILL
    } instr_t;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic       ZERO_EXT = 1'b0;
    localparam logic       SIGN_EXT = 1'b1;
    localparam logic [1:0] NO_SHIFT           = 2'b00;
    localparam logic [1:0] TWO_BITS_SHIFT     = 2'b01;
    localparam logic [1:0] SIXTEEN_BITS_SHIFT = 2'b10;
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_PASSB = 3'b011;
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_JR     = 2'b11;
    localparam logic       SRCA_RS   = 1'b1;
    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b10;
    localparam logic [1:0] DST_RT    = 2'b00;
    localparam logic [1:0] DST_RD    = 2'b01;
    localparam logic [1:0] DST_RA    = 2'b10;
    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath/memory bundle
//   datapath -> ctrl : opcode, funct, zero, imem_ready, dmem_ready
//   ctrl -> datapath : memory requests, write enables, mux selects, ALU/extender controls,
//                      illegal pulse, retire_cnt, debug state
interface mc_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             dmem_req;
    logic             IRWrite;
    logic             PCWrite;
    logic [1:0]       PCSrc;
    logic             EXTop;
    logic [1:0]       Shiftop;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUop;
    logic [1:0]       RegDst;
    logic [1:0]       MemtoReg;
    logic             RegWrite;
    logic             MemWrite;
    logic             illegal;
    logic [CNT_W-1:0] retire_cnt;
    logic [2:0]       state;
    modport master (
        input  opcode, funct, zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, IRWrite, PCWrite, PCSrc, EXTop, Shiftop, ALUSrcA, ALUSrcB,
               ALUop, RegDst, MemtoReg, RegWrite, MemWrite, illegal, retire_cnt, state
    );
    modport slave (
        output opcode, funct, zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, IRWrite, PCWrite, PCSrc, EXTop, Shiftop, ALUSrcA, ALUSrcB,
               ALUop, RegDst, MemtoReg, RegWrite, MemWrite, illegal, retire_cnt, state
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational opcode/funct -> instruction class, flags unsupported encodings
//   opcode, funct : instruction fields from IR
//   cls           : instruction class
//   illegal       : encoding is not a supported instruction
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output instr_t     cls,
    output logic       illegal
);
    always_comb begin
        cls = I_ILL;
        case (opcode)
            OP_RTYPE: cls = funct == FN_ADDU ? I_ADDU :
                            funct == FN_SUBU ? I_SUBU :
                            funct == FN_JR   ? I_JR   :
                            funct == FN_SLL  ? I_NOP  : I_ILL;
            OP_ORI:   cls = I_ORI;
            OP_LUI:   cls = I_LUI;
            OP_LW:    cls = I_LW;
            OP_SW:    cls = I_SW;
            OP_BEQ:   cls = I_BEQ;
            OP_J:     cls = I_J;
            OP_JAL:   cls = I_JAL;
            default:  cls = I_ILL;
        endcase
    end
    assign illegal = cls == I_ILL;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB) with retire counter
//   clk   : rising-edge clock
//   reset : asynchronous active-low; forces FETCH, clears retire_cnt, gates all requests/enables
//   bus   : controller side of mc_ctrl_if (decode inputs, ready handshakes, datapath controls)
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input logic       clk,
    input logic       reset,
    mc_ctrl_if.master bus
);
    import mc_ctrl_pkg::*;
    state_t           st, nxt;
    instr_t           cls;
    logic             ill;
    logic             retire;
    logic [CNT_W-1:0] cnt;

    mc_ctrl_decode u_dec (
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .cls     (cls),
        .illegal (ill)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st  <= S_FETCH;
            cnt <= '0;
        end else begin
            st <= nxt;
            if (retire) cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.state      = st;
    assign bus.retire_cnt = cnt;

    // Outputs are a pure function of state and current inputs; the reset term keeps every
    // request and enable low while reset is held, even though st already reads FETCH.
    always_comb begin
        nxt          = st;
        retire       = 1'b0;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.PCSrc    = PC_PLUS4;
        bus.EXTop    = ZERO_EXT;
        bus.Shiftop  = NO_SHIFT;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = SRCB_RT;
        bus.ALUop    = ALU_ADD;
        bus.RegDst   = DST_RT;
        bus.MemtoReg = WB_ALU;
        bus.RegWrite = 1'b0;
        bus.MemWrite = 1'b0;
        bus.illegal  = 1'b0;
        if (reset) begin
            case (st)
                S_FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        nxt         = S_DECODE;
                    end
                end
                // Branch target is precomputed into ALUOut here for every instruction.
                S_DECODE: begin
                    bus.EXTop    = SIGN_EXT;
                    bus.Shiftop  = TWO_BITS_SHIFT;
                    bus.ALUSrcB  = SRCB_EXT;
                    bus.illegal  = ill;
                    bus.PCWrite  = cls inside {I_J, I_JAL, I_JR};
                    bus.PCSrc    = cls == I_JR ? PC_JR : cls inside {I_J, I_JAL} ? PC_JUMP : PC_PLUS4;
                    bus.RegWrite = cls == I_JAL;
                    bus.RegDst   = cls == I_JAL ? DST_RA : DST_RT;
                    bus.MemtoReg = cls == I_JAL ? WB_PC : WB_ALU;
                    nxt          = cls inside {I_J, I_JAL, I_JR, I_NOP, I_ILL} ? S_FETCH : S_EXE;
                    retire       = cls inside {I_J, I_JAL, I_JR, I_NOP};
                end
                S_EXE: begin
                    bus.ALUSrcA = SRCA_RS;
                    bus.EXTop   = cls inside {I_LW, I_SW} ? SIGN_EXT : ZERO_EXT;
                    bus.Shiftop = cls == I_LUI ? SIXTEEN_BITS_SHIFT : NO_SHIFT;
                    bus.ALUSrcB = cls inside {I_ORI, I_LUI, I_LW, I_SW} ? SRCB_EXT : SRCB_RT;
                    bus.ALUop   = cls inside {I_SUBU, I_BEQ} ? ALU_SUB :
                                  cls == I_ORI ? ALU_OR :
                                  cls == I_LUI ? ALU_PASSB : ALU_ADD;
                    bus.PCWrite = cls == I_BEQ && bus.zero;
                    bus.PCSrc   = cls == I_BEQ ? PC_BRANCH : PC_PLUS4;
                    nxt         = cls inside {I_LW, I_SW} ? S_MEM : cls == I_BEQ ? S_FETCH : S_WB;
                    retire      = cls == I_BEQ;
                end
                S_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.MemWrite = cls == I_SW;
                    if (bus.dmem_ready) begin
                        nxt    = cls == I_SW ? S_FETCH : S_WB;
                        retire = cls == I_SW;
                    end
                end
                S_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = cls inside {I_ADDU, I_SUBU} ? DST_RD : DST_RT;
                    bus.MemtoReg = cls == I_LW ? WB_MDR : WB_ALU;
                    nxt          = S_FETCH;
                    retire       = 1'b1;
                end
                default: nxt = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed sequence over every supported instruction with a retire/latency scoreboard
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(32)) bus();

    mc_ctrl #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        string       tag;
        int          cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    int          start = 0;
    logic [31:0] model_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc_cnt++;
    endtask

    // FETCH cycle with zero-wait imem, then advance into DECODE.
    task automatic issue(input logic [31:0] ins, input string tag, input int cyc, input bit ret,
                         input bit track);
        bus.opcode     = ins[31:26];
        bus.funct      = ins[5:0];
        bus.imem_ready = 1'b1;
        #1;
        chk({tag, "_f_state"}, bus.state, 0);
        chk({tag, "_f_req"}, bus.imem_req, 1);
        chk({tag, "_f_irw"}, bus.IRWrite, 1);
        chk({tag, "_f_pcw"}, bus.PCWrite, 1);
        chk({tag, "_f_pcsrc"}, bus.PCSrc, 0);
        start = cyc_cnt;
        if (track) begin
            model_cnt += 32'(ret);
            sb.push_back('{tag, cyc, model_cnt});
        end
        tick();
        bus.imem_ready = 1'b0;
        #1;
        chk({tag, "_d_state"}, bus.state, 1);
    endtask

    task automatic complete();
        exp_t e;
        for (int i = 0; i < 16 && bus.state !== 3'd0; i++) tick();
        chk("done_state", bus.state, 0);
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_cycles"}, cyc_cnt - start, e.cyc);
            chk({e.tag, "_retire"}, bus.retire_cnt, e.ret);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.opcode     = 6'h00;
        bus.funct      = 6'h00;
        bus.zero       = 1'b0;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        #12;
        chk("rst_state", bus.state, 0);
        chk("rst_cnt", bus.retire_cnt, 0);
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_irw", bus.IRWrite, 0);
        chk("rst_pcw", bus.PCWrite, 0);
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick();
        chk("idle_state", bus.state, 0);
        chk("idle_req", bus.imem_req, 1);
        chk("idle_dreq", bus.dmem_req, 0);
        tick();
        chk("idle_state2", bus.state, 0);
        chk("idle_cnt", bus.retire_cnt, 0);
        bus.dmem_ready = 1'b0;

        issue(32'h3401FFFF, "ori", 4, 1, 1);
        chk("ori_d_ext", bus.EXTop, 1);
        chk("ori_d_shift", bus.Shiftop, 1);
        chk("ori_d_srca", bus.ALUSrcA, 0);
        chk("ori_d_srcb", bus.ALUSrcB, 2);
        tick();
        chk("ori_e_state", bus.state, 2);
        chk("ori_e_ext", bus.EXTop, 0);
        chk("ori_e_shift", bus.Shiftop, 0);
        chk("ori_e_aluop", bus.ALUop, 2);
        chk("ori_e_srca", bus.ALUSrcA, 1);
        chk("ori_e_srcb", bus.ALUSrcB, 2);
        tick();
        chk("ori_w_state", bus.state, 4);
        chk("ori_w_regw", bus.RegWrite, 1);
        chk("ori_w_dst", bus.RegDst, 0);
        chk("ori_w_m2r", bus.MemtoReg, 0);
        chk("ori_w_cnt", bus.retire_cnt, 0);
        complete();

        issue(32'h3C021234, "lui", 4, 1, 1);
        tick();
        chk("lui_e_shift", bus.Shiftop, 2);
        chk("lui_e_aluop", bus.ALUop, 3);
        chk("lui_e_ext", bus.EXTop, 0);
        chk("lui_e_srcb", bus.ALUSrcB, 2);
        tick();
        chk("lui_w_regw", bus.RegWrite, 1);
        chk("lui_w_dst", bus.RegDst, 0);
        complete();

        issue(32'h00221821, "addu", 4, 1, 1);
        tick();
        chk("addu_e_aluop", bus.ALUop, 0);
        chk("addu_e_srcb", bus.ALUSrcB, 0);
        chk("addu_e_srca", bus.ALUSrcA, 1);
        tick();
        chk("addu_w_regw", bus.RegWrite, 1);
        chk("addu_w_dst", bus.RegDst, 1);
        chk("addu_w_m2r", bus.MemtoReg, 0);
        complete();

        issue(32'h00221823, "subu", 4, 1, 1);
        tick();
        chk("subu_e_aluop", bus.ALUop, 1);
        complete();

        issue(32'h8C040000, "lw", 8, 1, 1);
        tick();
        chk("lw_e_state", bus.state, 2);
        chk("lw_e_ext", bus.EXTop, 1);
        chk("lw_e_shift", bus.Shiftop, 0);
        chk("lw_e_aluop", bus.ALUop, 0);
        chk("lw_e_srcb", bus.ALUSrcB, 2);
        tick();
        chk("lw_m_state", bus.state, 3);
        chk("lw_m_req", bus.dmem_req, 1);
        chk("lw_m_memw", bus.MemWrite, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("lw_m_hold", bus.state, 3);
            chk("lw_m_req_hold", bus.dmem_req, 1);
        end
        tick();
        bus.dmem_ready = 1'b1;
        #1;
        chk("lw_m_last", bus.state, 3);
        chk("lw_m_req_last", bus.dmem_req, 1);
        tick();
        bus.dmem_ready = 1'b0;
        #1;
        chk("lw_w_state", bus.state, 4);
        chk("lw_w_regw", bus.RegWrite, 1);
        chk("lw_w_dst", bus.RegDst, 0);
        chk("lw_w_m2r", bus.MemtoReg, 1);
        complete();

        issue(32'hAC050004, "sw", 4, 1, 1);
        tick();
        chk("sw_e_ext", bus.EXTop, 1);
        tick();
        bus.dmem_ready = 1'b1;
        #1;
        chk("sw_m_state", bus.state, 3);
        chk("sw_m_memw", bus.MemWrite, 1);
        chk("sw_m_req", bus.dmem_req, 1);
        tick();
        bus.dmem_ready = 1'b0;
        complete();

        issue(32'h10220003, "beq_t", 3, 1, 1);
        tick();
        bus.zero = 1'b1;
        #1;
        chk("beqt_e_pcw", bus.PCWrite, 1);
        chk("beqt_e_pcsrc", bus.PCSrc, 1);
        chk("beqt_e_aluop", bus.ALUop, 1);
        chk("beqt_e_srcb", bus.ALUSrcB, 0);
        tick();
        bus.zero = 1'b0;
        complete();

        issue(32'h10220003, "beq_nt", 3, 1, 1);
        tick();
        chk("beqn_e_state", bus.state, 2);
        chk("beqn_e_pcw", bus.PCWrite, 0);
        complete();

        issue(32'h0C000010, "jal", 2, 1, 1);
        chk("jal_d_regw", bus.RegWrite, 1);
        chk("jal_d_dst", bus.RegDst, 2);
        chk("jal_d_m2r", bus.MemtoReg, 2);
        chk("jal_d_pcsrc", bus.PCSrc, 2);
        chk("jal_d_pcw", bus.PCWrite, 1);
        complete();

        issue(32'h08000010, "j", 2, 1, 1);
        chk("j_d_pcsrc", bus.PCSrc, 2);
        chk("j_d_pcw", bus.PCWrite, 1);
        chk("j_d_regw", bus.RegWrite, 0);
        complete();

        issue(32'h03E00008, "jr", 2, 1, 1);
        chk("jr_d_pcsrc", bus.PCSrc, 3);
        chk("jr_d_pcw", bus.PCWrite, 1);
        complete();

        issue(32'h00000000, "nop", 2, 1, 1);
        chk("nop_d_pcw", bus.PCWrite, 0);
        chk("nop_d_regw", bus.RegWrite, 0);
        chk("nop_d_ill", bus.illegal, 0);
        complete();

        issue(32'hFC000000, "ill_op", 2, 0, 1);
        chk("illop_d_ill", bus.illegal, 1);
        chk("illop_d_pcw", bus.PCWrite, 0);
        chk("illop_d_regw", bus.RegWrite, 0);
        tick();
        chk("illop_pulse_end", bus.illegal, 0);
        complete();

        issue(32'h00221825, "ill_fn", 2, 0, 1);
        chk("illfn_d_ill", bus.illegal, 1);
        complete();

        issue(32'hAC050004, "sw_rst", 4, 1, 0);
        tick();
        tick();
        chk("swr_m_state", bus.state, 3);
        chk("swr_m_memw", bus.MemWrite, 1);
        chk("swr_m_req", bus.dmem_req, 1);
        reset = 1'b0;
        model_cnt = 0;
        #1;
        chk("swr_memw_drop", bus.MemWrite, 0);
        chk("swr_req_drop", bus.dmem_req, 0);
        chk("swr_state", bus.state, 0);
        chk("swr_cnt", bus.retire_cnt, 0);
        tick();
        chk("swr_hold_state", bus.state, 0);
        reset = 1'b1;

        issue(32'h3401FFFF, "ori2", 4, 1, 1);
        complete();
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
